mf8_lpm: RTL and testbench
==========================

# mf8_lpm

Load-from-program-memory sequencer for the mf8 core. It executes LPM-class instructions: it takes the Z pointer from the register file and fetches the addressed byte from the 16-bit-wide program ROM. It writes the byte to the destination register and, for the post-increment form, writes Z+1 back to r30/r31. It sits between the decoder, the program ROM read port and the register-file write port, driving the write side of the register file.

## Interface

Parameters: none.

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle request; sampled only when Busy=0
- Rd_Dst  in  5  destination register index, captured with Start
- Post_Inc  in  1  1 = LPM Rd,Z+ form; captured with Start
- Z  in  16  current Z pointer (byte address), captured with Start
- ROM_Addr  out  15  program ROM word address
- ROM_Rd  out  1  ROM read strobe
- ROM_Data  in  16  ROM read data; valid exactly one cycle after ROM_Rd
- Wr  out  1  register-file write strobe
- Wr_Addr  out  5  register-file write index
- Wr_Data  out  8  register-file write data
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle completion pulse

## Operation

- States: IDLE, FETCH, WAIT, WR_D, WR_ZL, WR_ZH, DONE.
- IDLE behaviour:
  - Start=1 captures Z into Zc, Rd_Dst into Dc and Post_Inc into Pc, then moves to FETCH.
  - Start=0 stays in IDLE.
  - Start is ignored in all other states. There is no queueing.
- FETCH:
  - ROM_Rd=1 and ROM_Addr=Zc[15:1].
  - Moves to WAIT.
- WAIT:
  - Samples ROM_Data and selects a byte.
  - Zc[0]=0 selects ROM_Data[7:0]; Zc[0]=1 selects ROM_Data[15:8].
  - The selected byte is held in a data register. Moves to WR_D.
- WR_D:
  - Wr=1, Wr_Addr=Dc, Wr_Data=selected byte.
  - Moves to WR_ZL if Pc=1, otherwise to DONE.
- Zi = Zc+1, computed modulo 2^16 (0xFFFF wraps to 0x0000). There is no carry out.
- WR_ZL: Wr=1, Wr_Addr=30, Wr_Data=Zi[7:0]. Moves to WR_ZH.
- WR_ZH: Wr=1, Wr_Addr=31, Wr_Data=Zi[15:8]. Moves to DONE.
- DONE: Done=1. Moves to IDLE.
- Destination overlap: with Post_Inc=1 and Dc equal to 30 or 31, all three writes still occur in order. The Z write-back is last, so the final register value is Zi.
- Z changing on the input after capture has no effect. Only Zc is used.
- Outputs in any state without a listed assignment:
  - ROM_Rd=0 and Wr=0.
  - Wr_Addr and Wr_Data are 0.
  - ROM_Addr holds its last value.
- Reset (async, any state, including mid-operation):
  - State goes to IDLE.
  - All outputs go to 0: ROM_Addr=0, ROM_Rd=0, Wr=0, Wr_Addr=0, Wr_Data=0, Busy=0, Done=0.
  - Captured registers are cleared.
  - No write is issued after reset is released until a new Start.

## Timing

- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths.
- Cycle numbering: cycle 0 is the cycle in which Start=1 is sampled at its closing edge.

| Cycle | State | Signals |
|---|---|---|
| 1 | FETCH | ROM_Rd=1, Busy=1 |
| 2 | WAIT | ROM_Data valid |
| 3 | WR_D | Wr=1 |
| 4 | DONE (Post_Inc=0) | Done=1 |
| 4 | WR_ZL (Post_Inc=1) | |
| 5 | WR_ZH (Post_Inc=1) | |
| 6 | DONE (Post_Inc=1) | Done=1 |

- Latency from Start to Done: 4 cycles, or 6 with post-increment.
- Busy=1 from cycle 1 through the DONE cycle inclusive.
- Minimum Start-to-Start spacing: 5 cycles without post-increment, 7 with it.
- A Start in the DONE cycle is ignored. The next Start is accepted from the IDLE cycle that follows.
- Each register write occupies exactly one cycle. Wr, Wr_Addr and Wr_Data change together.

## Test plan

- **Reset values:** assert Reset asynchronously, between clock edges -> all outputs read 0 immediately and state is IDLE.
- **Low byte, no increment:** ROM word 0x0123 = 0xBEEF; Start with Z=0x0246, Rd_Dst=5, Post_Inc=0. Required response:
  - ROM_Rd=1 with ROM_Addr=0x0123 in cycle 1.
  - Wr=1, Wr_Addr=5, Wr_Data=0xEF in cycle 3.
  - Done=1 in cycle 4, and no further Wr.
- **High byte with post-increment:** same ROM word, Z=0x0247, Rd_Dst=16, Post_Inc=1. Required writes:
  - (16, 0xBE) in cycle 3.
  - (30, 0x48) in cycle 4.
  - (31, 0x02) in cycle 5.
  - Done in cycle 6.
- **Wrap-around and destination overlap:** Z=0xFFFF, ROM word 0x7FFF = 0x5A00, Rd_Dst=30, Post_Inc=1. Required writes, in order: (30, 0x5A), (30, 0x00), (31, 0x00). Done in cycle 6.
- **Start while busy:** pulse Start again in cycles 2 and 4 of a Post_Inc=0 operation -> both pulses ignored, with exactly one ROM_Rd and one Wr. A Start in cycle 5 (IDLE) is accepted, with ROM_Rd=1 in cycle 6.
- **Reset mid-operation:** assert Reset during WR_ZL of a Post_Inc=1 operation -> Wr drops to 0 immediately, WR_ZH never occurs, Done never pulses, and Busy=0.

Source files
------------

// File: rtl/mf8_lpm.sv
`default_nettype none
// ============================================================================
// Module   : mf8_lpm
// Purpose  : LPM-class sequencer. Fetches the program-ROM byte addressed by
//            Z, writes it to Rd, and for the Z+ form writes Z+1 to r30/r31.
// Revision : 1.0 - initial release
// ============================================================================
module mf8_lpm (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [4:0]  Rd_Dst,
  input  logic        Post_Inc,
  input  logic [15:0] Z,
  output logic [14:0] ROM_Addr,
  output logic        ROM_Rd,
  input  logic [15:0] ROM_Data,
  output logic        Wr,
  output logic [4:0]  Wr_Addr,
  output logic [7:0]  Wr_Data,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_WR_D  = 3'd3,
    S_WR_ZL = 3'd4,
    S_WR_ZH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [4:0] c_ZL_IDX = 5'd30;
  localparam logic [4:0] c_ZH_IDX = 5'd31;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_zc;
  logic [4:0]  r_dc;
  logic        r_pc;
  logic [7:0]  r_data;
  logic [14:0] r_rom_addr;
  logic [15:0] w_zi;

  // Incremented pointer wraps naturally at 16 bits; no carry out is kept.
  assign w_zi     = r_zc + 16'd1;
  assign ROM_Addr = r_rom_addr;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Capture operands on accepted Start; grab the selected ROM byte in WAIT.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_zc       <= 16'd0;
      r_dc       <= 5'd0;
      r_pc       <= 1'b0;
      r_data     <= 8'd0;
      r_rom_addr <= 15'd0;
    end else begin
      if (r_state == S_IDLE && Start) begin
        r_zc       <= Z;
        r_dc       <= Rd_Dst;
        r_pc       <= Post_Inc;
        // Loaded here so it is already valid during FETCH and then holds.
        r_rom_addr <= Z[15:1];
      end
      if (r_state == S_WAIT) begin
        r_data <= r_zc[0] ? ROM_Data[15:8] : ROM_Data[7:0];
      end
    end
  end

  // Next-state and output decode from registered state only.
  always_comb begin
    w_next  = r_state;
    ROM_Rd  = 1'b0;
    Wr      = 1'b0;
    Wr_Addr = 5'd0;
    Wr_Data = 8'd0;
    Busy    = 1'b1;
    Done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) w_next = S_FETCH;
      end
      S_FETCH: begin
        ROM_Rd = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_next = S_WR_D;
      end
      S_WR_D: begin
        Wr      = 1'b1;
        Wr_Addr = r_dc;
        Wr_Data = r_data;
        w_next  = r_pc ? S_WR_ZL : S_DONE;
      end
      S_WR_ZL: begin
        Wr      = 1'b1;
        Wr_Addr = c_ZL_IDX;
        Wr_Data = w_zi[7:0];
        w_next  = S_WR_ZH;
      end
      S_WR_ZH: begin
        Wr      = 1'b1;
        Wr_Addr = c_ZH_IDX;
        Wr_Data = w_zi[15:8];
        w_next  = S_DONE;
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        Busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mf8_lpm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mf8_lpm
// Purpose  : Self-checking bench for mf8_lpm: vector table plus hand-written
//            sequences for busy-Start and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mf8_lpm;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [4:0]  Rd_Dst = 5'd0;
  logic        Post_Inc = 1'b0;
  logic [15:0] Z = 16'd0;
  logic [14:0] ROM_Addr;
  logic        ROM_Rd;
  logic [15:0] ROM_Data = 16'd0;
  logic        Wr;
  logic [4:0]  Wr_Addr;
  logic [7:0]  Wr_Data;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_errors = 0;

  mf8_lpm dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Rd_Dst(Rd_Dst),
    .Post_Inc(Post_Inc), .Z(Z), .ROM_Addr(ROM_Addr), .ROM_Rd(ROM_Rd),
    .ROM_Data(ROM_Data), .Wr(Wr), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Program ROM contents used by the vectors.
  function automatic logic [15:0] rom_word(input logic [14:0] a);
    case (a)
      15'h0123: rom_word = 16'hBEEF;
      15'h7FFF: rom_word = 16'h5A00;
      15'h0000: rom_word = 16'h1234;
      15'h4321: rom_word = 16'hCAFE;
      default:  rom_word = 16'hDEAD;
    endcase
  endfunction

  // ROM read port: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge Clk) begin
    if (ROM_Rd) ROM_Data <= rom_word(ROM_Addr);
    else        ROM_Data <= 16'($urandom);
  end

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t exp_q[$];

  typedef struct {
    logic [15:0] z;
    logic [4:0]  rd;
    logic        pinc;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run one operation. Must be called at a negedge during an IDLE cycle.
  // mask[k] = 1 re-pulses Start (with junk operands) in cycle k.
  task automatic run_op(input vec_t v, input logic [7:0] mask);
    logic [15:0] zi;
    int done_k, rd_cnt, done_cnt;
    wr_t w;
    zi = v.z + 16'd1;
    done_k = v.pinc ? 6 : 4;
    rd_cnt = 0;
    done_cnt = 0;
    chk("idle_before_start", {31'd0, Busy}, 32'd0);
    exp_q.push_back('{addr: v.rd, data: v.exp_byte, cyc: 3});
    if (v.pinc) begin
      exp_q.push_back('{addr: 5'd30, data: zi[7:0],  cyc: 4});
      exp_q.push_back('{addr: 5'd31, data: zi[15:8], cyc: 5});
    end
    Z = v.z; Rd_Dst = v.rd; Post_Inc = v.pinc; Start = 1'b1;
    for (int k = 1; k <= done_k; k++) begin
      @(negedge Clk);
      chk("busy", {31'd0, Busy}, 32'd1);
      if (ROM_Rd) begin
        rd_cnt++;
        chk("rom_rd_cycle", k, 1);
        chk("rom_addr", {17'd0, ROM_Addr}, {17'd0, v.z[15:1]});
      end
      if (Done) begin
        done_cnt++;
        chk("done_cycle", k, done_k);
      end
      if (Wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", {27'd0, Wr_Addr}, 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", {27'd0, Wr_Addr}, {27'd0, w.addr});
          chk("wr_data", {24'd0, Wr_Data}, {24'd0, w.data});
          chk("wr_cycle", k, w.cyc);
        end
      end
      // Start and operands are scrambled after capture; only Zc may be used.
      Start = mask[k];
      Z = 16'($urandom);
      Rd_Dst = 5'($urandom);
      Post_Inc = 1'($urandom);
    end
    chk("writes_missing", exp_q.size(), 0);
    chk("rom_rd_count", rd_cnt, 1);
    chk("done_count", done_cnt, 1);
    exp_q.delete();
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{z: 16'h0246, rd: 5'd5,  pinc: 1'b0, exp_byte: 8'hEF};
    vecs[1] = '{z: 16'h0247, rd: 5'd16, pinc: 1'b1, exp_byte: 8'hBE};
    vecs[2] = '{z: 16'hFFFF, rd: 5'd30, pinc: 1'b1, exp_byte: 8'h5A};
    vecs[3] = '{z: 16'h0000, rd: 5'd0,  pinc: 1'b1, exp_byte: 8'h34};
    vecs[4] = '{z: 16'h8643, rd: 5'd31, pinc: 1'b1, exp_byte: 8'hCA};
    vecs[5] = '{z: 16'h8642, rd: 5'd31, pinc: 1'b0, exp_byte: 8'hFE};
    vecs[6] = '{z: 16'h00FF, rd: 5'd7,  pinc: 1'b1, exp_byte: 8'hDE};

    // Asynchronous reset between edges, before any clock edge has occurred.
    #2 Reset = 1'b1;
    #1;
    chk("rst_rom_addr", {17'd0, ROM_Addr}, 32'd0);
    chk("rst_rom_rd",   {31'd0, ROM_Rd},   32'd0);
    chk("rst_wr",       {31'd0, Wr},       32'd0);
    chk("rst_wr_addr",  {27'd0, Wr_Addr},  32'd0);
    chk("rst_wr_data",  {24'd0, Wr_Data},  32'd0);
    chk("rst_busy",     {31'd0, Busy},     32'd0);
    chk("rst_done",     {31'd0, Done},     32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Vector table, issued at minimum Start-to-Start spacing.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], 8'h00);
      @(negedge Clk);
    end

    // Start pulses in cycles 2 and 4 (DONE) are ignored; cycle 5 is accepted.
    run_op(vecs[0], 8'b0001_0100);
    @(negedge Clk);
    run_op(vecs[4], 8'h00);
    @(negedge Clk);

    // Reset during WR_ZL.
    Z = 16'h0247; Rd_Dst = 5'd16; Post_Inc = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    chk("pre_rst_wr",      {31'd0, Wr},      32'd1);
    chk("pre_rst_wr_addr", {27'd0, Wr_Addr}, 32'd30);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_wr",       {31'd0, Wr},       32'd0);
    chk("mid_rst_wr_addr",  {27'd0, Wr_Addr},  32'd0);
    chk("mid_rst_wr_data",  {24'd0, Wr_Data},  32'd0);
    chk("mid_rst_busy",     {31'd0, Busy},     32'd0);
    chk("mid_rst_done",     {31'd0, Done},     32'd0);
    chk("mid_rst_rom_addr", {17'd0, ROM_Addr}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      chk("post_rst_wr",   {31'd0, Wr},     32'd0);
      chk("post_rst_done", {31'd0, Done},   32'd0);
      chk("post_rst_busy", {31'd0, Busy},   32'd0);
      chk("post_rst_rd",   {31'd0, ROM_Rd}, 32'd0);
    end

    // Recovery after reset.
    v = vecs[6];
    run_op(v, 8'h00);
    @(negedge Clk);
    chk("final_idle", {31'd0, Busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
